load_store_ctrl: RTL and testbench

Multicycle load/store sequencer between the main control unit and the single-port `Memoria` block. It accepts one memory request at a time over a valid/ready handshake. It handles word, halfword and byte loads and stores, doing read-modify-write for sub-word stores, and returns extracted and extended load data with a one-cycle response pulse. Misaligned addresses and illegal opcodes are reported as errors and never reach memory.

---
 rtl/load_store_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_load_store_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_ctrl.sv
// load_store_ctrl: multicycle load/store sequencer between the control unit and a single-port
// synchronous memory. One request at a time over a valid/ready handshake. Word, halfword and
// byte loads and stores are supported; sub-word stores use read-modify-write. Misaligned
// accesses and illegal opcodes complete with an error and never touch memory.
//
// Ports:
//   Clk, Reset           rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_op               000 LW, 001 LH, 010 LB, 011 SW, 100 SH, 101 SB, 11x illegal
//   req_addr, req_wdata  byte address and store data (SH: [15:0], SB: [7:0])
//   resp_valid           one-cycle completion pulse
//   resp_err             error flag qualifying resp_valid
//   resp_rdata           load result, 0 for stores/errors, held until next completion
//   mem_addr, mem_wr     word address and write enable towards memory
//   mem_wdata, mem_rdata write data and read data (read data valid one cycle after address)
module load_store_ctrl #(
    parameter bit SIGN_EXT = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OpLw = 3'b000;
    localparam logic [2:0] OpLh = 3'b001;
    localparam logic [2:0] OpLb = 3'b010;
    localparam logic [2:0] OpSw = 3'b011;
    localparam logic [2:0] OpSh = 3'b100;
    localparam logic [2:0] OpSb = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    // Holds the store data on acceptance; replaced by the merged word for sub-word stores.
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_bad;
    logic        is_load;
    logic [31:0] rd_shift;
    logic [31:0] load_val;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // Illegal opcode or misaligned access for the requested size.
    always_comb begin
        req_bad = 1'b0;
        case (req_op)
            OpLw, OpSw: req_bad = (req_addr[1:0] != 2'b00);
            OpLh, OpSh: req_bad = req_addr[0];
            OpLb, OpSb: req_bad = 1'b0;
            default:    req_bad = 1'b1;
        endcase
    end

    assign is_load = (op_q == OpLw) || (op_q == OpLh) || (op_q == OpLb);

    // Little-endian: shifting right by 8*addr[1:0] puts the addressed lane at bit 0.
    assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = mem_rdata;
        case (op_q)
            OpLh:    load_val = {{16{SIGN_EXT & rd_shift[15]}}, rd_shift[15:0]};
            OpLb:    load_val = {{24{SIGN_EXT & rd_shift[7]}}, rd_shift[7:0]};
            default: load_val = mem_rdata;
        endcase
    end

    // Replicate the store data across all lanes, then pick per byte with the lane enables.
    always_comb begin
        if (op_q == OpSh) begin
            lane_en   = 4'b0011 << addr_q[1:0];
            lane_data = {2{data_q[15:0]}};
        end else begin
            lane_en   = 4'b0001 << addr_q[1:0];
            lane_data = {4{data_q[7:0]}};
        end
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = lane_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    data_d = req_wdata;
                    err_d  = req_bad;
                    if (req_bad) begin
                        rdata_d = 32'h0;
                        state_d = StResp;
                    end else if (req_op == OpSw) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                state_d = StWait;
            end
            StWait: begin
                if (is_load) begin
                    rdata_d = load_val;
                    state_d = StResp;
                end else begin
                    data_d  = merged;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                rdata_d = 32'h0;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // All outputs decode from registered state only.
    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_err   = (state_q == StResp) && err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = (state_q == StIdle) ? 32'h0 : {addr_q[31:2], 2'b00};
    assign mem_wr     = (state_q == StWrite);
    assign mem_wdata  = (state_q == StWrite) ? data_q : 32'h0;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Scoreboard bench for load_store_ctrl. Two instances (zero- and sign-extending) share the
// same request stream, each with its own synchronous memory. A byte-level reference memory
// produces expected responses and memory writes, which a negedge monitor compares.
module tb_load_store_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy0, rdy1, rv0, rv1, re0, re1, mw0, mw1;
    logic [31:0] rd0, rd1, ma0, ma1, mwd0, mwd1;
    logic [31:0] mrd0 = 32'h0;
    logic [31:0] mrd1 = 32'h0;

    always #5 Clk = ~Clk;

    load_store_ctrl #(.SIGN_EXT(1'b0)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(rdy0), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0), .resp_err(re0),
        .resp_rdata(rd0), .mem_addr(ma0), .mem_wr(mw0), .mem_wdata(mwd0), .mem_rdata(mrd0)
    );

    load_store_ctrl #(.SIGN_EXT(1'b1)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(rdy1), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_err(re1),
        .resp_rdata(rd1), .mem_addr(ma1), .mem_wr(mw1), .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    // Synchronous single-port memories, 16 words, aliased on address bits [5:2].
    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];

    always @(posedge Clk) begin
        mrd0 <= mem0[ma0[5:2]];
        mrd1 <= mem1[ma1[5:2]];
        if (mw0) mem0[ma0[5:2]] <= mwd0;
        if (mw1) mem1[ma1[5:2]] <= mwd1;
    end

    // Reference memory as 64 bytes.
    logic [7:0] ref_b [64];

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] addr;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t       rq[$];
    wr_t         wq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          free_cyc = 0;
    logic        mon_en = 1'b0;
    logic [31:0] held0 = 32'h0;
    logic [31:0] held1 = 32'h0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input int wa);
        return {ref_b[wa+3], ref_b[wa+2], ref_b[wa+1], ref_b[wa]};
    endfunction

    // Monitor: responses, memory writes, held data and idle outputs.
    always @(negedge Clk) begin
        resp_t e;
        wr_t   w;
        if (mon_en) begin
            chk("ready_match", 32'(rdy0), 32'(rdy1));
            if (rdy0) begin
                chk("idle_mem_addr", ma0, 32'h0);
                chk("idle_mem_wr", 32'({mw0, mw1}), 32'h0);
            end
            if (rv0 || rv1) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 32'({rv0, rv1}), 32'h0);
                end else begin
                    e = rq.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_valid_both", 32'({rv0, rv1}), 32'h3);
                    chk("resp_err0", 32'(re0), 32'(e.err));
                    chk("resp_err1", 32'(re1), 32'(e.err));
                    chk("resp_rdata0", rd0, e.r0);
                    chk("resp_rdata1", rd1, e.r1);
                    chk("resp_mem_addr", ma0, e.addr);
                    chk("resp_mem_wr", 32'({mw0, mw1}), 32'h0);
                    held0 = e.r0;
                    held1 = e.r1;
                end
            end else begin
                chk("err_outside_resp", 32'({re0, re1}), 32'h0);
                chk("rdata_hold0", rd0, held0);
                chk("rdata_hold1", rd1, held1);
                if (rq.size() > 0 && rq[0].cyc < cyc) begin
                    chk("resp_missing", cyc, rq[0].cyc);
                    void'(rq.pop_front());
                end
            end
            if (mw0 || mw1) begin
                if (wq.size() == 0) begin
                    chk("write_unexpected", 32'({mw0, mw1}), 32'h0);
                end else begin
                    w = wq.pop_front();
                    chk("write_cycle", cyc, w.cyc);
                    chk("write_both", 32'({mw0, mw1}), 32'h3);
                    chk("write_addr0", ma0, w.addr);
                    chk("write_addr1", ma1, w.addr);
                    chk("write_data0", mwd0, w.data);
                    chk("write_data1", mwd1, w.data);
                end
            end else if (wq.size() > 0 && wq[0].cyc < cyc) begin
                chk("write_missing", cyc, wq[0].cyc);
                void'(wq.pop_front());
            end
        end
    end

    // Drive junk while busy until the DUT is due to be idle; ready must follow exactly.
    task automatic wait_free();
        while (cyc < free_cyc) begin
            chk("busy_ready", 32'({rdy0, rdy1}), 32'h0);
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 3'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            @(negedge Clk);
        end
        chk("free_ready", 32'({rdy0, rdy1}), 32'h3);
    endtask

    // Issue one request; call at a negedge. Computes the expected outcome from ref_b.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int gap);
        int          ai, wa, lat, t;
        logic        bad;
        logic [15:0] h;
        logic [7:0]  b;
        resp_t       e;
        wr_t         w;
        wait_free();
        for (int i = 0; i < gap; i++) begin
            req_valid = 1'b0;
            req_op    = 3'($urandom);
            req_addr  = $urandom;
            @(negedge Clk);
            chk("gap_ready", 32'({rdy0, rdy1}), 32'h3);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        t  = cyc;
        ai = int'(addr[5:0]);
        wa = ai - (ai % 4);
        bad = (op > 3'd5) || ((op == 3'd0 || op == 3'd3) && (ai % 4 != 0)) ||
              ((op == 3'd1 || op == 3'd4) && (ai % 2 != 0));
        e.err  = bad;
        e.r0   = 32'h0;
        e.r1   = 32'h0;
        e.addr = {addr[31:2], 2'b00};
        if (bad) begin
            lat = 1;
        end else begin
            case (op)
                3'd0: begin
                    lat  = 3;
                    e.r0 = ref_word(ai);
                    e.r1 = e.r0;
                end
                3'd1: begin
                    lat  = 3;
                    h    = {ref_b[ai+1], ref_b[ai]};
                    e.r0 = {16'h0, h};
                    e.r1 = {{16{h[15]}}, h};
                end
                3'd2: begin
                    lat  = 3;
                    b    = ref_b[ai];
                    e.r0 = {24'h0, b};
                    e.r1 = {{24{b[7]}}, b};
                end
                3'd3: begin
                    lat = 2;
                    for (int k = 0; k < 4; k++) ref_b[ai+k] = wd[8*k +: 8];
                end
                3'd4: begin
                    lat = 4;
                    ref_b[ai]   = wd[7:0];
                    ref_b[ai+1] = wd[15:8];
                end
                default: begin
                    lat = 4;
                    ref_b[ai] = wd[7:0];
                end
            endcase
            if (op >= 3'd3) begin
                w.cyc  = t + lat - 1;
                w.addr = {addr[31:2], 2'b00};
                w.data = ref_word(wa);
                wq.push_back(w);
            end
        end
        e.cyc = t + lat;
        rq.push_back(e);
        free_cyc = t + lat + 1;
        @(negedge Clk);
        req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'({rdy0, rdy1}), 32'h3);
        chk({tag, "_resp_valid"}, 32'({rv0, rv1}), 32'h0);
        chk({tag, "_resp_err"}, 32'({re0, re1}), 32'h0);
        chk({tag, "_rdata0"}, rd0, 32'h0);
        chk({tag, "_rdata1"}, rd1, 32'h0);
        chk({tag, "_mem_addr"}, ma0 | ma1, 32'h0);
        chk({tag, "_mem_wr"}, 32'({mw0, mw1}), 32'h0);
        chk({tag, "_mem_wdata"}, mwd0 | mwd1, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, a, wd;
        logic [2:0]  op;
        Reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            v = (i == 4) ? 32'hAABBCCDD : $urandom;
            mem0[i] = v;
            mem1[i] = v;
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = v[8*k +: 8];
        end
        @(negedge Clk);
        chk_reset_outputs("reset_held");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        free_cyc = cyc;
        mon_en = 1'b1;

        // Directed sequence on word 0x10 = 0xAABBCCDD.
        issue(3'd0, 32'h10, 32'h0, 0);          // LW
        issue(3'd2, 32'h12, 32'h0, 0);          // LB
        issue(3'd1, 32'h12, 32'h0, 1);          // LH
        issue(3'd2, 32'h10, 32'h0, 0);          // LB
        issue(3'd5, 32'h11, 32'h12345677, 0);   // SB
        issue(3'd0, 32'h10, 32'h0, 0);          // LW
        issue(3'd4, 32'h12, 32'h0000BEEF, 0);   // SH
        issue(3'd0, 32'h10, 32'h0, 0);          // LW
        issue(3'd3, 32'h16, 32'h11111111, 0);   // SW misaligned
        issue(3'd1, 32'h13, 32'h0, 0);          // LH misaligned
        issue(3'd0, 32'h11, 32'h0, 0);          // LW misaligned
        issue(3'd7, 32'h10, 32'h22222222, 0);   // illegal op
        issue(3'd0, 32'h10, 32'h0, 0);          // LW, word unchanged by errors
        issue(3'd3, 32'h20, 32'hCAFEF00D, 0);   // SW directly after LW
        issue(3'd0, 32'h20, 32'h0, 0);

        // Reset during WAIT of SH 0x10: store abandoned, memory untouched.
        wait_free();
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_addr  = 32'h10;
        req_wdata = 32'h00005A5A;
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk);
        mon_en = 1'b0;
        #1 Reset = 1'b1;
        #1 chk_reset_outputs("reset_async");
        @(negedge Clk);
        chk_reset_outputs("reset_hold");
        @(negedge Clk);
        Reset = 1'b0;
        chk("reset_mem0", mem0[4], ref_word(16));
        chk("reset_mem1", mem1[4], ref_word(16));
        held0 = 32'h0;
        held1 = 32'h0;
        @(negedge Clk);
        free_cyc = cyc;
        mon_en = 1'b1;
        issue(3'd0, 32'h10, 32'h0, 0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op == 3'd0 || op == 3'd3) a[1:0] = 2'b00;
                if (op == 3'd1 || op == 3'd4) a[0] = 1'b0;
            end
            wd = $urandom;
            issue(op, a, wd, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        wait_free();
        for (int i = 0; i < 20 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge Clk);
        chk("drain_resp", rq.size(), 32'h0);
        chk("drain_write", wq.size(), 32'h0);
        for (int i = 0; i < 16; i++) chk("final_mem", mem0[i], ref_word(4*i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
